// File: rtl/switch_pkg.sv
// Shared constants, port/state types and pointer helper for the crossbar scheduler.
package switch_pkg;
   localparam int PORT_CNT    = 4;
   localparam int SLOT_CYCLES = 8;
   localparam int BLOCK_BYTES = 32;

   typedef logic [1:0] port_t;
   typedef enum logic [1:0] {IDLE, GRANT, ACCEPT, HOLD} state_t;

   // Round-robin pointer advance with wrap at n-1.
   function automatic port_t port_inc(port_t p, int n);
      return (int'(p) == n - 1) ? port_t'(0) : port_t'(p + 2'd1);
   endfunction
endpackage

// File: rtl/crossbar_sched_if.sv
// Request/match bundle between the VOQ front end and the crossbar scheduler.
interface crossbar_sched_if #(parameter int PORT_CNT = switch_pkg::PORT_CNT);
   logic                         sched_en;
   logic [PORT_CNT*PORT_CNT-1:0] voq_req;
   logic [PORT_CNT-1:0]          match_valid;
   logic [2*PORT_CNT-1:0]        match_egress;
   logic                         slot_start;
   logic                         slot_last;

   modport master (output sched_en, voq_req,
                   input  match_valid, match_egress, slot_start, slot_last);
   modport slave  (input  sched_en, voq_req,
                   output match_valid, match_egress, slot_start, slot_last);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational PORT_CNT-way round-robin picker: first set req bit at or after ptr.
module rr_arbiter #(parameter int PORT_CNT = switch_pkg::PORT_CNT) (
   input  logic [PORT_CNT-1:0] req,
   input  switch_pkg::port_t   ptr,
   output logic [PORT_CNT-1:0] onehot,
   output switch_pkg::port_t   idx
);
   switch_pkg::port_t cand;
   logic              found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = ptr;
      for (int k = 0; k < PORT_CNT; k++) begin
         cand = switch_pkg::port_t'((int'(ptr) + k) % PORT_CNT);
         if (!found && req[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            idx          = cand;
         end
      end
   end
endmodule

// File: rtl/crossbar_sched.sv
// Single-iteration iSLIP crossbar scheduler; one match is held per fixed-length slot.
module crossbar_sched #(
   parameter int PORT_CNT    = switch_pkg::PORT_CNT,
   parameter int SLOT_CYCLES = switch_pkg::SLOT_CYCLES
) (
   input logic             clk,
   input logic             reset,
   crossbar_sched_if.slave bus
);
   import switch_pkg::*;

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

   state_t                             state;
   logic [CNT_W-1:0]                   slot_cnt;
   port_t [PORT_CNT-1:0]               g_ptr, a_ptr;
   logic  [PORT_CNT-1:0][PORT_CNT-1:0] grant_req, grant_oh, grant_r;  // [egress][ingress]
   logic  [PORT_CNT-1:0][PORT_CNT-1:0] acc_req, acc_oh;               // [ingress][egress]
   port_t [PORT_CNT-1:0]               grant_idx, grant_idx_r, acc_idx;
   logic  [PORT_CNT-1:0]               egress_acc;
   logic  [PORT_CNT-1:0]               match_valid;
   port_t [PORT_CNT-1:0]               match_egress;
   logic                               slot_start, slot_last;

   for (genvar j = 0; j < PORT_CNT; j++) begin : g_grant
      for (genvar i = 0; i < PORT_CNT; i++) begin : g_req
         assign grant_req[j][i] = bus.voq_req[i*PORT_CNT + j];
      end
      rr_arbiter #(.PORT_CNT(PORT_CNT)) u_arb (
         .req(grant_req[j]), .ptr(g_ptr[j]), .onehot(grant_oh[j]), .idx(grant_idx[j]));
   end

   for (genvar i = 0; i < PORT_CNT; i++) begin : g_accept
      for (genvar j = 0; j < PORT_CNT; j++) begin : g_req
         assign acc_req[i][j] = grant_r[j][i];
      end
      rr_arbiter #(.PORT_CNT(PORT_CNT)) u_arb (
         .req(acc_req[i]), .ptr(a_ptr[i]), .onehot(acc_oh[i]), .idx(acc_idx[i]));
   end

   // Egresses whose grant was taken up; only these advance their grant pointer.
   always_comb begin
      egress_acc = '0;
      for (int i = 0; i < PORT_CNT; i++) egress_acc |= acc_oh[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         slot_cnt     <= '0;
         g_ptr        <= '0;
         a_ptr        <= '0;
         grant_r      <= '0;
         grant_idx_r  <= '0;
         match_valid  <= '0;
         match_egress <= '0;
         slot_start   <= 1'b0;
         slot_last    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.sched_en) state <= GRANT;
            GRANT: begin
               grant_r     <= grant_oh;
               grant_idx_r <= grant_idx;
               if (bus.voq_req != '0) state <= ACCEPT;
               else if (!bus.sched_en) state <= IDLE;
            end
            ACCEPT: begin
               match_egress <= acc_idx;
               for (int i = 0; i < PORT_CNT; i++) begin
                  match_valid[i] <= |acc_oh[i];
                  if (|acc_oh[i]) a_ptr[i] <= port_inc(acc_idx[i], PORT_CNT);
               end
               for (int j = 0; j < PORT_CNT; j++)
                  if (egress_acc[j]) g_ptr[j] <= port_inc(grant_idx_r[j], PORT_CNT);
               slot_cnt   <= '0;
               slot_start <= 1'b1;
               slot_last  <= (SLOT_CYCLES == 1);
               state      <= HOLD;
            end
            HOLD: begin
               slot_start <= 1'b0;
               if (slot_cnt == CNT_LAST) begin
                  slot_cnt    <= '0;
                  slot_last   <= 1'b0;
                  match_valid <= '0;
                  state       <= bus.sched_en ? GRANT : IDLE;
               end else begin
                  slot_cnt  <= slot_cnt + 1'b1;
                  slot_last <= (slot_cnt == CNT_W'(SLOT_CYCLES - 2));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.match_valid  = match_valid;
   assign bus.match_egress = match_egress;
   assign bus.slot_start   = slot_start;
   assign bus.slot_last    = slot_last;
endmodule

// File: tb/tb_crossbar_sched.sv
// Directed bench for crossbar_sched: latency, slot framing, iSLIP pointer behaviour, reset.
module tb_crossbar_sched;
   import switch_pkg::*;

   logic clk, reset;
   int   checks = 0;
   int   errors = 0;

   crossbar_sched_if #(.PORT_CNT(4)) bus ();
   crossbar_sched #(.PORT_CNT(4), .SLOT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (bus.slot_start !== 1'b1 && n < 30) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(bus.slot_start), 32'd1);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      bus.sched_en = 1'b0;
      bus.voq_req = '0;
      tick(2);
      reset = 1'b0;
   endtask

   function automatic logic [7:0] emask(input logic [3:0] v);
      logic [7:0] m = '0;
      for (int i = 0; i < 4; i++) if (v[i]) m[2*i +: 2] = 2'b11;
      return m;
   endfunction

   // Full-contention expectations from pointers all zero (slots 1..7).
   logic [3:0] pv_exp [7] = '{4'b0001, 4'b0011, 4'b0111, 4'hF, 4'hF, 4'hF, 4'hF};
   logic [7:0] pe_exp [7] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C, 8'hB1, 8'hC6};

   initial begin
      logic [15:0] served;
      logic [3:0]  v;
      logic [7:0]  e;

      // Reset state
      reset = 1'b1; bus.sched_en = 1'b0; bus.voq_req = '0;
      tick(2);
      chk("rst_valid",  32'(bus.match_valid),  32'd0);
      chk("rst_egress", 32'(bus.match_egress), 32'd0);
      chk("rst_start",  32'(bus.slot_start),   32'd0);
      chk("rst_last",   32'(bus.slot_last),    32'd0);
      chk("rst_state",  32'(dut.state),        32'(IDLE));

      // No requests: parked in GRANT
      reset = 1'b0; bus.sched_en = 1'b1;
      tick(1);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("idle_req_state", 32'(dut.state), 32'(GRANT));
         chk("idle_req_valid", 32'(bus.match_valid), 32'd0);
      end

      // Single request ingress 2 -> egress 1, two-cycle latency
      bus.voq_req = 16'h0200;
      tick(1);
      chk("single_acc_state", 32'(dut.state), 32'(ACCEPT));
      chk("single_acc_valid", 32'(bus.match_valid), 32'd0);
      tick(1);
      chk("single_valid", 32'(bus.match_valid), 32'b0100);
      chk("single_egress", 32'(bus.match_egress[5:4]), 32'd1);
      chk("single_start", 32'(bus.slot_start), 32'd1);
      chk("single_last0", 32'(bus.slot_last), 32'd0);
      bus.voq_req = '0;
      for (int k = 1; k < 8; k++) begin
         tick(1);
         chk("single_hold_valid", 32'(bus.match_valid), 32'b0100);
         chk("single_hold_egress", 32'(bus.match_egress[5:4]), 32'd1);
         chk("single_hold_start", 32'(bus.slot_start), 32'd0);
         chk("single_hold_last", 32'(bus.slot_last), (k == 7) ? 32'd1 : 32'd0);
      end
      tick(1);
      chk("single_end_valid", 32'(bus.match_valid), 32'd0);
      chk("single_end_last", 32'(bus.slot_last), 32'd0);
      chk("single_end_state", 32'(dut.state), 32'(GRANT));
      tick(3);
      chk("single_after_state", 32'(dut.state), 32'(GRANT));
      chk("single_after_valid", 32'(bus.match_valid), 32'd0);

      // Full contention: desync over slots 1-3, perfect permutations in 4-7
      do_reset();
      bus.sched_en = 1'b1; bus.voq_req = 16'hFFFF;
      served = '0;
      for (int s = 0; s < 7; s++) begin
         wait_start("full_start");
         v = bus.match_valid;
         e = bus.match_egress;
         chk("full_valid", 32'(v), 32'(pv_exp[s]));
         chk("full_egress", 32'(e & emask(pv_exp[s])), 32'(pe_exp[s]));
         if (s >= 3)
            for (int i = 0; i < 4; i++)
               if (v[i]) served[i*4 + int'(e[2*i +: 2])] = 1'b1;
         tick(1);
      end
      chk("full_fairness", 32'(served), 32'hFFFF);

      // Two ingresses want only egress 3: g[3] walks 0->1->2
      do_reset();
      bus.sched_en = 1'b1; bus.voq_req = 16'h0088;
      wait_start("e3_start1");
      chk("e3_valid1", 32'(bus.match_valid), 32'b0001);
      chk("e3_egress1", 32'(bus.match_egress[1:0]), 32'd3);
      chk("e3_gptr1", 32'(dut.g_ptr[3]), 32'd1);
      tick(1);
      wait_start("e3_start2");
      chk("e3_valid2", 32'(bus.match_valid), 32'b0010);
      chk("e3_egress2", 32'(bus.match_egress[3:2]), 32'd3);
      chk("e3_gptr2", 32'(dut.g_ptr[3]), 32'd2);

      // sched_en dropped at count 3: slot runs to completion, then IDLE
      tick(3);
      chk("drop_cnt", 32'(dut.slot_cnt), 32'd3);
      bus.sched_en = 1'b0;
      for (int k = 4; k < 8; k++) begin
         tick(1);
         chk("drop_hold_valid", 32'(bus.match_valid), 32'b0010);
         chk("drop_hold_last", 32'(bus.slot_last), (k == 7) ? 32'd1 : 32'd0);
      end
      tick(1);
      chk("drop_state", 32'(dut.state), 32'(IDLE));
      chk("drop_valid", 32'(bus.match_valid), 32'd0);
      tick(3);
      chk("drop_stay_state", 32'(dut.state), 32'(IDLE));
      chk("drop_stay_valid", 32'(bus.match_valid), 32'd0);

      // Reset at count 5 aborts the slot
      do_reset();
      bus.sched_en = 1'b1; bus.voq_req = 16'h0200;
      wait_start("rst5_start");
      tick(5);
      chk("rst5_cnt", 32'(dut.slot_cnt), 32'd5);
      chk("rst5_gptr_pre", 32'(dut.g_ptr[1]), 32'd3);
      chk("rst5_aptr_pre", 32'(dut.a_ptr[2]), 32'd2);
      reset = 1'b1;
      tick(1);
      chk("rst5_valid", 32'(bus.match_valid), 32'd0);
      chk("rst5_egress", 32'(bus.match_egress), 32'd0);
      chk("rst5_start", 32'(bus.slot_start), 32'd0);
      chk("rst5_last", 32'(bus.slot_last), 32'd0);
      chk("rst5_state", 32'(dut.state), 32'(IDLE));
      chk("rst5_gptr", 32'(dut.g_ptr), 32'd0);
      chk("rst5_aptr", 32'(dut.a_ptr), 32'd0);
      chk("rst5_cnt0", 32'(dut.slot_cnt), 32'd0);
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
